// File: rtl/spi_slave.sv
// spi_slave -- SPI mode-0 slave front end for the packet controller.
// Brings SCK/MOSI/CS_N into the clk domain, deserialises MSB-first bytes onto
// rx_data/rx_stb and serialises the controller's tx_data byte onto spi_miso.
// Build macro SPI_MISO_TRISTATE_EN: release spi_miso (1'bz) while idle or in
// reset so MISO can be shared; otherwise spi_miso is driven low when idle.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  output logic       tsx_start
);

  // Pin lanes carried side by side through the synchroniser.
  localparam int LANES  = 3;
  localparam int L_SCK  = 0;
  localparam int L_MOSI = 1;
  localparam int L_CS   = 2;
  // Idle pin levels: SCK low, MOSI low, CS_N high -> reset makes no edges.
  localparam logic [LANES-1:0] PIN_RST = 3'b100;
  // First reply byte is loaded this many cycles after the tsx_start cycle.
  localparam int LOAD_DLY = 2;

  typedef enum logic {IDLE, ACTIVE} state_t;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("spi_slave: SYNC_STAGES must be 2..4");
    end
  endgenerate

  logic [SYNC_STAGES-1:0][LANES-1:0] sync_q;
  logic [LANES-1:0]                  pin_s;
  logic [LANES-1:0]                  hist_q;
  logic                              sck_rise;
  logic                              sck_fall;
  logic                              cs_fall;
  logic                              cs_rise;
  logic                              mosi_s;
  logic [SYNC_STAGES:0]              flush_pipe;
  logic                              armed;
  state_t                            state;
  logic [2:0]                        bit_cnt;
  logic [6:0]                        rx_shift;
  logic [7:0]                        tx_shift;
  logic                              byte_done;
  logic [LOAD_DLY:0]                 vld_pipe;

  // Synchroniser chain for all three pins, followed by one edge-history stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{PIN_RST}};
      hist_q <= PIN_RST;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {spi_cs_n, spi_mosi, spi_sck}};
      hist_q <= pin_s;
    end
  end

  assign pin_s    = sync_q[SYNC_STAGES-1];
  assign sck_rise =  pin_s[L_SCK] & ~hist_q[L_SCK];
  assign sck_fall = ~pin_s[L_SCK] &  hist_q[L_SCK];
  assign cs_fall  = ~pin_s[L_CS]  &  hist_q[L_CS];
  assign cs_rise  =  pin_s[L_CS]  & ~hist_q[L_CS];
  // MOSI from the history stage: sampled just before the detected SCK rise,
  // well inside the half-period where the host holds it stable.
  assign mosi_s   = hist_q[L_MOSI];

  // After reset the chain still holds reset levels; wait until it carries real
  // pin values and CS reads high, so a CS held low across reset cannot look
  // like a fresh frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pipe <= '0;
      armed      <= 1'b0;
    end else begin
      flush_pipe <= {flush_pipe[SYNC_STAGES-1:0], 1'b1};
      if (flush_pipe[SYNC_STAGES] && pin_s[L_CS] && hist_q[L_CS])
        armed <= 1'b1;
    end
  end

  // Frame FSM with bit counter, receive deserialiser and reply serialiser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      rx_stb    <= 1'b0;
      tsx_start <= 1'b0;
      byte_done <= 1'b0;
      vld_pipe  <= '0;
    end else begin
      rx_stb    <= 1'b0;
      tsx_start <= 1'b0;
      vld_pipe  <= {vld_pipe[LOAD_DLY-1:0], 1'b0};
      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state     <= ACTIVE;
            tsx_start <= 1'b1;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            byte_done <= 1'b0;
            vld_pipe  <= {{LOAD_DLY{1'b0}}, 1'b1};
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // CS wins over any SCK edge in the same cycle; partial byte dropped.
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            vld_pipe  <= '0;
          end else begin
            if (sck_rise) begin
              rx_shift <= {rx_shift[5:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= {rx_shift, mosi_s};
                rx_stb    <= 1'b1;
                byte_done <= 1'b1;
              end
            end
            // Header byte load gets priority; host timing keeps SCK quiet then.
            if (vld_pipe[LOAD_DLY]) begin
              tx_shift <= tx_data;
            end else if (sck_fall) begin
              if (bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
              end else if (byte_done) begin
                tx_shift  <= tx_data;
                byte_done <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MISO pin: current reply bit while a frame is active.
`ifdef SPI_MISO_TRISTATE_EN
  assign spi_miso = (state == ACTIVE && !rst) ? tx_shift[7] : 1'bz;
`else
  assign spi_miso = (state == ACTIVE) && !rst && tx_shift[7];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- directed bench for spi_slave with a queue-based byte model.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_miso;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic       tsx_start;

  int checks   = 0;
  int failures = 0;

  // Model: bytes the host has fully clocked in, in order, awaiting a strobe.
  logic [7:0] exp_rx[$];
  logic [7:0] model_rx = 8'h00;
  // Reply bytes the controller presents after each strobe.
  logic [7:0] tx_q[$];
  // Per-frame stimulus.
  logic [7:0] fr_rx[$];
  logic [7:0] fr_tx[$];

  int     tsx_cnt  = 0;
  int     stb_cnt  = 0;
  longint cyc      = 0;
  longint last_stb = -1;
  logic   prev_tsx = 1'b0;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_miso  (spi_miso),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_stb    (rx_stb),
    .tsx_start (tsx_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_miso_idle(input string name);
`ifdef SPI_MISO_TRISTATE_EN
    chk(name, {31'b0, spi_miso}, {31'b0, 1'bz});
`else
    chk(name, {31'b0, spi_miso}, 32'd0);
`endif
  endtask

  // Every cycle: strobes must match the model queue, rx_data must hold otherwise.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        model_rx = 8'h00;
        exp_rx.delete();
        prev_tsx = 1'b0;
        last_stb = -1;
      end else begin
        if (tsx_start) begin
          tsx_cnt++;
          chk("tsx_one_cycle", {31'b0, prev_tsx}, 32'd0);
        end
        prev_tsx = tsx_start;
        if (rx_stb) begin
          stb_cnt++;
          if (exp_rx.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_stb_unexpected actual=%h required=no_strobe", rx_data);
            model_rx = rx_data;
          end else begin
            model_rx = exp_rx.pop_front();
            chk("rx_data_on_stb", rx_data, model_rx);
          end
          if (last_stb >= 0)
            chk("stb_spacing_ge32", {31'b0, (cyc - last_stb) >= 32}, 32'd1);
          last_stb = cyc;
        end else begin
          chk("rx_data_hold", rx_data, model_rx);
        end
      end
    end
  end

  // Controller stand-in: next reply byte one cycle after each strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_stb && !rst && tx_q.size() > 0) begin
        @(posedge clk);
        #1 tx_data = tx_q.pop_front();
      end
    end
  end

  // Clock bits hi..lo of b, mode 0; MISO captured at each SCK rise.
  task automatic clock_bits(input logic [7:0] b, input int hi, input int lo,
                            input int half, input bit push, output logic [7:0] mo);
    mo = 8'h00;
    for (int i = hi; i >= lo; i--) begin
      spi_mosi = b[i];
      #(half);
      mo[i]   = spi_miso;
      spi_sck = 1'b1;
      if (push && i == 0) exp_rx.push_back(b);
      #(half);
      spi_sck = 1'b0;
    end
  endtask

  // One CS frame sending fr_rx while the controller replies with fr_tx.
  task automatic run_frame(input int half, input string tag);
    logic [7:0] mo;
    tx_q.delete();
    tx_data = fr_tx[0];
    for (int k = 1; k < fr_tx.size(); k++) tx_q.push_back(fr_tx[k]);
    spi_cs_n = 1'b0;
    #120;
    for (int k = 0; k < fr_rx.size(); k++) begin
      clock_bits(fr_rx[k], 7, 0, half, 1'b1, mo);
      chk({tag, "_miso"}, mo, fr_tx[k]);
    end
    #60 spi_cs_n = 1'b1;
    #200;
    chk({tag, "_all_strobes"}, exp_rx.size(), 32'd0);
  endtask

  initial begin
    int t0;
    int s0;
    logic [7:0] mo;
    rst      = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_data", rx_data, 32'h00);
    chk("reset_rx_stb", {31'b0, rx_stb}, 32'd0);
    chk("reset_tsx_start", {31'b0, tsx_start}, 32'd0);
    chk_miso_idle("reset_miso");
    #100;

    // Single byte
    t0 = tsx_cnt; s0 = stb_cnt;
    fr_rx.delete(); fr_tx.delete();
    fr_rx.push_back(8'h03); fr_tx.push_back(8'hA5);
    run_frame(40, "single");
    chk("single_rx_data", rx_data, 32'h03);
    chk("single_tsx_count", tsx_cnt - t0, 32'd1);
    chk("single_stb_count", stb_cnt - s0, 32'd1);

    // Back-to-back bytes
    t0 = tsx_cnt; s0 = stb_cnt;
    fr_rx.delete(); fr_tx.delete();
    fr_rx.push_back(8'h02); fr_rx.push_back(8'h10); fr_rx.push_back(8'h55);
    fr_tx.push_back(8'hA5); fr_tx.push_back(8'h11); fr_tx.push_back(8'h22);
    run_frame(40, "b2b");
    chk("b2b_rx_data", rx_data, 32'h55);
    chk("b2b_tsx_count", tsx_cnt - t0, 32'd1);
    chk("b2b_stb_count", stb_cnt - s0, 32'd3);

    // Aborted byte, then a fresh frame
    t0 = tsx_cnt; s0 = stb_cnt;
    spi_cs_n = 1'b0;
    #120;
    clock_bits(8'hFF, 7, 3, 40, 1'b0, mo);
    #60 spi_cs_n = 1'b1;
    #200;
    chk("abort_no_stb", stb_cnt - s0, 32'd0);
    fr_rx.delete(); fr_tx.delete();
    fr_rx.push_back(8'hC3); fr_tx.push_back(8'h3C);
    run_frame(40, "abort_next");
    chk("abort_rx_data", rx_data, 32'hC3);
    chk("abort_tsx_count", tsx_cnt - t0, 32'd2);
    chk("abort_stb_count", stb_cnt - s0, 32'd1);

    // Idle noise
    t0 = tsx_cnt; s0 = stb_cnt;
    repeat (16) begin
      #40 spi_sck = ~spi_sck;
    end
    #100;
    chk("idle_tsx_count", tsx_cnt - t0, 32'd0);
    chk("idle_stb_count", stb_cnt - s0, 32'd0);
    chk_miso_idle("idle_miso");

    // Reset mid-byte with CS held low
    t0 = tsx_cnt; s0 = stb_cnt;
    tx_data  = 8'h5A;
    spi_cs_n = 1'b0;
    #120;
    clock_bits(8'hB7, 7, 5, 40, 1'b0, mo);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rx_data", rx_data, 32'h00);
    chk_miso_idle("rstmid_miso");
    clock_bits(8'hB7, 4, 0, 40, 1'b0, mo);
    #60 spi_cs_n = 1'b1;
    #200;
    chk("rstmid_tsx_count", tsx_cnt - t0, 32'd1);
    chk("rstmid_stb_count", stb_cnt - s0, 32'd0);
    chk("rstmid_rx_hold", rx_data, 32'h00);
    fr_rx.delete(); fr_tx.delete();
    fr_rx.push_back(8'h96); fr_tx.push_back(8'h69);
    run_frame(40, "rstmid_next");
    chk("rstmid_next_rx", rx_data, 32'h96);
    chk("rstmid_next_tsx", tsx_cnt - t0, 32'd2);

    // Edge-phase sweep: 10 frames x 10 random bytes, random SCK phase/period
    for (int f = 0; f < 10; f++) begin
      int half;
      half = 40 + int'($urandom_range(0, 7));
      fr_rx.delete(); fr_tx.delete();
      for (int k = 0; k < 10; k++) begin
        fr_rx.push_back(8'($urandom_range(0, 255)));
        fr_tx.push_back(8'($urandom_range(0, 255)));
      end
      #($urandom_range(1, 9));
      run_frame(half, "sweep");
    end

    #200;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
